// File: rtl/pong_game_engine.sv
// pong_game_engine
//   Frame-rate Pong core. Holds both paddles, the ball, both scores and the
//   SERVE/PLAY/POINT/GAMEOVER sequencer. Game state advances once per frame,
//   on the first clock where iVS is seen high after being low. Every pixel
//   clock it also classifies (x_pos, y_pos) as background, paddle or ball.
// Ports
//   iVGA_CLK, iRST_n        pixel clock, async active-low reset
//   iVS                     vsync; its rising edge is the frame tick
//   x_pos, y_pos            current pixel coordinate
//   w_in/s_in, o_in/l_in    left / right paddle up / down (level)
//   serve_in                serve / restart request (level)
//   paddle_l_y, paddle_r_y  paddle top edges
//   ball_x, ball_y          ball top-left corner
//   score_l, score_r        scores, saturating at WIN_SCORE
//   game_over               high while the game has ended
//   obj_code                00 background, 01 paddle, 10 ball (1-cycle latency)
module pong_game_engine #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_H     = 40,
  parameter int PADDLE_L_X   = 20,
  parameter int PADDLE_R_X   = 610,
  parameter int PADDLE_STEP  = 4,
  parameter int EDGE_MARGIN  = 10,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_STEP    = 2,
  parameter int WIN_SCORE    = 7,
  parameter int PAUSE_FRAMES = 60,
  parameter int SCORE_W      = 4
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic               iVS,
  input  logic [9:0]         x_pos,
  input  logic [9:0]         y_pos,
  input  logic               w_in,
  input  logic               s_in,
  input  logic               o_in,
  input  logic               l_in,
  input  logic               serve_in,
  output logic [9:0]         paddle_l_y,
  output logic [9:0]         paddle_r_y,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic [1:0]         obj_code
);

  localparam int CNT_W = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;

  localparam logic [9:0] PAD_CY    = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [9:0] PAD_MIN   = 10'(EDGE_MARGIN);
  localparam logic [9:0] PAD_MAX   = 10'(V_ACTIVE - EDGE_MARGIN - PADDLE_H);
  localparam logic [9:0] PAD_STEP  = 10'(PADDLE_STEP);
  localparam logic [9:0] BALL_CX   = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_CY   = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_LAST = 10'(BALL_SIZE - 1);
  localparam logic [9:0] PLX       = 10'(PADDLE_L_X);
  localparam logic [9:0] PRX       = 10'(PADDLE_R_X);
  localparam logic [9:0] PW        = 10'(PADDLE_W);
  localparam logic [9:0] PH        = 10'(PADDLE_H);
  localparam logic [9:0] X_AFTER_L = 10'(PADDLE_L_X + PADDLE_W + 1);
  localparam logic [9:0] X_AFTER_R = 10'(PADDLE_R_X - BALL_SIZE);

  localparam logic signed [11:0] S_STEP = 12'(BALL_STEP);
  localparam logic signed [11:0] S_BALL = 12'(BALL_SIZE);
  localparam logic signed [11:0] S_H    = 12'(H_ACTIVE);
  localparam logic signed [11:0] S_V    = 12'(V_ACTIVE);
  localparam logic signed [11:0] S_PH   = 12'(PADDLE_H);
  localparam logic signed [11:0] S_PLX  = 12'(PADDLE_L_X);
  localparam logic signed [11:0] S_PRX  = 12'(PADDLE_R_X);
  localparam logic signed [11:0] S_PW   = 12'(PADDLE_W);

  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   PAUSE_LAST = CNT_W'(PAUSE_FRAMES - 1);

  typedef enum logic [1:0] {
    S_SERVE    = 2'd0,
    S_PLAY     = 2'd1,
    S_POINT    = 2'd2,
    S_GAMEOVER = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_vs_d;
  logic [9:0]         r_paddle_l_y, r_paddle_r_y, r_ball_x, r_ball_y;
  logic               r_dir_x_neg, r_dir_y_neg;
  logic [SCORE_W-1:0] r_score_l, r_score_r;
  logic [CNT_W-1:0]   r_pause;
  logic               r_game_over;
  logic [1:0]         r_obj_code;

  logic               w_tick;
  logic signed [11:0] w_bx, w_by, w_pl, w_pr, w_nx, w_ny, w_by_nxt;
  logic               w_dir_y_neg_nxt, w_ovl_l, w_ovl_r;
  logic               w_hit_l, w_hit_r, w_miss_l, w_miss_r;
  logic               w_on_ball, w_on_pad;

  // Moves a paddle one step, clamping exactly onto the margin limits.
  function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic up, input logic dn);
    logic [9:0] res;
    res = y;
    if (up && !dn) begin
      if (y < PAD_MIN + PAD_STEP) res = PAD_MIN;
      else                        res = y - PAD_STEP;
    end else if (dn && !up) begin
      if (y > PAD_MAX - PAD_STEP) res = PAD_MAX;
      else                        res = y + PAD_STEP;
    end else begin
      res = y;
    end
    return res;
  endfunction

  // Score increment that sticks at the winning score.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    if (s >= WIN) return s;
    else          return s + SCORE_W'(1);
  endfunction

  assign w_tick = iVS & ~r_vs_d;

  // Candidate ball position, wall bounce and paddle/edge collision flags.
  always_comb begin
    w_bx = $signed({2'b00, r_ball_x});
    w_by = $signed({2'b00, r_ball_y});
    w_pl = $signed({2'b00, r_paddle_l_y});
    w_pr = $signed({2'b00, r_paddle_r_y});
    w_nx = r_dir_x_neg ? (w_bx - S_STEP) : (w_bx + S_STEP);
    w_ny = r_dir_y_neg ? (w_by - S_STEP) : (w_by + S_STEP);
    w_by_nxt        = w_ny;
    w_dir_y_neg_nxt = r_dir_y_neg;
    if (w_ny < 12'sd0) begin
      w_by_nxt        = 12'sd0;
      w_dir_y_neg_nxt = 1'b0;
    end else if (w_ny + S_BALL > S_V) begin
      w_by_nxt        = S_V - S_BALL;
      w_dir_y_neg_nxt = 1'b1;
    end else begin
      w_by_nxt        = w_ny;
      w_dir_y_neg_nxt = r_dir_y_neg;
    end
    // Overlap uses the ball rows it occupies now against the paddle's inclusive span.
    w_ovl_l  = (w_by <= w_pl + S_PH) && (w_by + S_BALL - 12'sd1 >= w_pl);
    w_ovl_r  = (w_by <= w_pr + S_PH) && (w_by + S_BALL - 12'sd1 >= w_pr);
    w_hit_l  = r_dir_x_neg && (w_nx <= S_PLX + S_PW) && (w_nx + S_BALL > S_PLX) && w_ovl_l;
    w_hit_r  = !r_dir_x_neg && (w_nx + S_BALL > S_PRX) && (w_nx <= S_PRX + S_PW) && w_ovl_r;
    w_miss_l = (w_nx <= 12'sd0);
    w_miss_r = (w_nx + S_BALL >= S_H);
  end

  // Frame-rate game state: paddles, ball, scores and the game sequencer.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state      <= S_SERVE;
      r_vs_d       <= 1'b0;
      r_paddle_l_y <= PAD_CY;
      r_paddle_r_y <= PAD_CY;
      r_ball_x     <= BALL_CX;
      r_ball_y     <= BALL_CY;
      r_dir_x_neg  <= 1'b0;
      r_dir_y_neg  <= 1'b0;
      r_score_l    <= '0;
      r_score_r    <= '0;
      r_pause      <= '0;
      r_game_over  <= 1'b0;
    end else begin
      r_vs_d <= iVS;
      if (w_tick) begin
        if (r_state != S_GAMEOVER) begin
          r_paddle_l_y <= paddle_next(r_paddle_l_y, w_in, s_in);
          r_paddle_r_y <= paddle_next(r_paddle_r_y, o_in, l_in);
        end
        case (r_state)
          S_SERVE: begin
            if (serve_in) r_state <= S_PLAY;
          end
          S_PLAY: begin
            r_ball_y    <= w_by_nxt[9:0];
            r_dir_y_neg <= w_dir_y_neg_nxt;
            // A paddle hit wins over an edge miss detected in the same frame.
            if (w_hit_l) begin
              r_ball_x    <= X_AFTER_L;
              r_dir_x_neg <= 1'b0;
            end else if (w_hit_r) begin
              r_ball_x    <= X_AFTER_R;
              r_dir_x_neg <= 1'b1;
            end else if (w_miss_l) begin
              r_score_r   <= sat_inc(r_score_r);
              r_ball_x    <= BALL_CX;
              r_ball_y    <= BALL_CY;
              r_dir_x_neg <= 1'b0;
              r_pause     <= '0;
              r_state     <= S_POINT;
            end else if (w_miss_r) begin
              r_score_l   <= sat_inc(r_score_l);
              r_ball_x    <= BALL_CX;
              r_ball_y    <= BALL_CY;
              r_dir_x_neg <= 1'b1;
              r_pause     <= '0;
              r_state     <= S_POINT;
            end else begin
              r_ball_x <= w_nx[9:0];
            end
          end
          S_POINT: begin
            if (r_pause == PAUSE_LAST) begin
              if ((r_score_l == WIN) || (r_score_r == WIN)) begin
                r_state     <= S_GAMEOVER;
                r_game_over <= 1'b1;
              end else begin
                r_state <= S_SERVE;
              end
            end else begin
              r_pause <= r_pause + CNT_W'(1);
            end
          end
          S_GAMEOVER: begin
            if (serve_in) begin
              r_score_l    <= '0;
              r_score_r    <= '0;
              r_paddle_l_y <= PAD_CY;
              r_paddle_r_y <= PAD_CY;
              r_ball_x     <= BALL_CX;
              r_ball_y     <= BALL_CY;
              r_dir_x_neg  <= 1'b0;
              r_dir_y_neg  <= 1'b0;
              r_game_over  <= 1'b0;
              r_state      <= S_SERVE;
            end
          end
          default: r_state <= S_SERVE;
        endcase
      end
    end
  end

  assign w_on_ball = (x_pos >= r_ball_x) && (x_pos <= r_ball_x + BALL_LAST) &&
                     (y_pos >= r_ball_y) && (y_pos <= r_ball_y + BALL_LAST);
  assign w_on_pad  = ((x_pos >= PLX) && (x_pos <= PLX + PW) &&
                      (y_pos >= r_paddle_l_y) && (y_pos <= r_paddle_l_y + PH)) ||
                     ((x_pos >= PRX) && (x_pos <= PRX + PW) &&
                      (y_pos >= r_paddle_r_y) && (y_pos <= r_paddle_r_y + PH));

  // Pixel classification register; the ball is drawn on top of a paddle.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_obj_code <= 2'b00;
    end else if (w_on_ball) begin
      r_obj_code <= 2'b10;
    end else if (w_on_pad) begin
      r_obj_code <= 2'b01;
    end else begin
      r_obj_code <= 2'b00;
    end
  end

  assign paddle_l_y = r_paddle_l_y;
  assign paddle_r_y = r_paddle_r_y;
  assign ball_x     = r_ball_x;
  assign ball_y     = r_ball_y;
  assign score_l    = r_score_l;
  assign score_r    = r_score_r;
  assign game_over  = r_game_over;
  assign obj_code   = r_obj_code;

endmodule

// File: tb/tb_pong_game_engine.sv
module tb_pong_game_engine;

  logic       iVGA_CLK = 1'b0;
  logic       iRST_n   = 1'b0;
  logic       iVS      = 1'b0;
  logic [9:0] x_pos    = 10'd0;
  logic [9:0] y_pos    = 10'd0;
  logic       w_in = 1'b0, s_in = 1'b0, o_in = 1'b0, l_in = 1'b0, serve_in = 1'b0;
  logic [9:0] paddle_l_y, paddle_r_y, ball_x, ball_y;
  logic [3:0] score_l, score_r;
  logic       game_over;
  logic [1:0] obj_code;
  logic [50:0] dut_vec;

  int checks = 0;
  int errors = 0;

  // Reference model: ints in screen pixels; mode 0 serve, 1 play, 2 point, 3 over
  int m_pl, m_pr, m_bx, m_by, m_dx, m_dy, m_sl, m_sr, m_cnt, m_mode, m_obj;
  int m_left_hits;
  bit m_vs_d;
  int phase;

  pong_game_engine dut (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .iVS(iVS), .x_pos(x_pos), .y_pos(y_pos),
    .w_in(w_in), .s_in(s_in), .o_in(o_in), .l_in(l_in), .serve_in(serve_in),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y), .ball_x(ball_x), .ball_y(ball_y),
    .score_l(score_l), .score_r(score_r), .game_over(game_over), .obj_code(obj_code)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  assign dut_vec = {paddle_l_y, paddle_r_y, ball_x, ball_y, score_l, score_r, game_over, obj_code};

  function automatic logic [50:0] exp_vec();
    return {10'(m_pl), 10'(m_pr), 10'(m_bx), 10'(m_by), 4'(m_sl), 4'(m_sr),
            (m_mode == 3), 2'(m_obj)};
  endfunction

  function automatic int move_pad(input int y, input bit up, input bit dn);
    if (up && !dn) return (y - 4 < 10) ? 10 : y - 4;
    if (dn && !up) return (y + 4 > 430) ? 430 : y + 4;
    return y;
  endfunction

  function automatic int classify(input int px, input int py);
    if (px >= m_bx && px <= m_bx + 7 && py >= m_by && py <= m_by + 7) return 2;
    if ((px >= 20 && px <= 30 && py >= m_pl && py <= m_pl + 40) ||
        (px >= 610 && px <= 620 && py >= m_pr && py <= m_pr + 40)) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_pl = 220; m_pr = 220; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
    m_sl = 0; m_sr = 0; m_cnt = 0; m_mode = 0; m_obj = 0; m_vs_d = 1'b0; phase = 0;
  endtask

  task automatic model_tick(input bit ul, input bit dl, input bit ur, input bit dr, input bit sv);
    int opl, opr, nx, ny;
    bit lh, rh;
    opl = m_pl; opr = m_pr;
    if (m_mode != 3) begin
      m_pl = move_pad(m_pl, ul, dl);
      m_pr = move_pad(m_pr, ur, dr);
    end
    case (m_mode)
      0: if (sv) m_mode = 1;
      1: begin
        nx = m_bx + 2 * m_dx;
        ny = m_by + 2 * m_dy;
        lh = (m_dx < 0) && nx <= 30 && nx + 8 > 20 && m_by <= opl + 40 && m_by + 7 >= opl;
        rh = (m_dx > 0) && nx + 8 > 610 && nx <= 620 && m_by <= opr + 40 && m_by + 7 >= opr;
        if (ny < 0) begin m_by = 0; m_dy = 1; end
        else if (ny + 8 > 480) begin m_by = 472; m_dy = -1; end
        else m_by = ny;
        if (lh) begin m_bx = 31; m_dx = 1; m_left_hits++; end
        else if (rh) begin m_bx = 602; m_dx = -1; end
        else if (nx <= 0) begin
          if (m_sr < 7) m_sr++;
          m_bx = 316; m_by = 236; m_dx = 1; m_cnt = 0; m_mode = 2;
        end else if (nx + 8 >= 640) begin
          if (m_sl < 7) m_sl++;
          m_bx = 316; m_by = 236; m_dx = -1; m_cnt = 0; m_mode = 2;
        end else m_bx = nx;
      end
      2: if (m_cnt == 59) m_mode = (m_sl == 7 || m_sr == 7) ? 3 : 0; else m_cnt++;
      default: if (sv) begin
        m_sl = 0; m_sr = 0; m_pl = 220; m_pr = 220; m_bx = 316; m_by = 236;
        m_dx = 1; m_dy = 1; m_mode = 0;
      end
    endcase
  endtask

  // One pixel clock; inputs are driven at the falling edge, px < 0 means random pixel.
  task automatic step(input bit ul, input bit dl, input bit ur, input bit dr, input bit sv,
                      input int px, input int py);
    w_in = ul; s_in = dl; o_in = ur; l_in = dr; serve_in = sv;
    x_pos = (px < 0) ? 10'($urandom_range(0, 639)) : 10'(px);
    y_pos = (py < 0) ? 10'($urandom_range(0, 479)) : 10'(py);
    iVS = (phase < 2);
    m_obj = classify(int'(x_pos), int'(y_pos));
    if (iVS && !m_vs_d) model_tick(ul, dl, ur, dr, sv);
    m_vs_d = iVS;
    phase = (phase + 1) % 4;
    @(posedge iVGA_CLK);
    @(negedge iVGA_CLK);
  endtask

  task automatic frame(input bit ul, input bit dl, input bit ur, input bit dr, input bit sv);
    for (int i = 0; i < 4; i++) step(ul, dl, ur, dr, sv, -1, -1);
  endtask

  task automatic do_reset();
    @(negedge iVGA_CLK);
    iRST_n = 1'b0; iVS = 1'b0;
    w_in = 1'b0; s_in = 1'b0; o_in = 1'b0; l_in = 1'b0; serve_in = 1'b0;
    model_reset();
    repeat (3) @(negedge iVGA_CLK);
    iRST_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge iVGA_CLK);
    iRST_n = 1'b0;
    @(negedge iVGA_CLK);
    checks++;
    if (dut_vec !== {10'd220, 10'd220, 10'd316, 10'd236, 4'd0, 4'd0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", dut_vec,
               {10'd220, 10'd220, 10'd316, 10'd236, 4'd0, 4'd0, 1'b0, 2'b00});
    end
    do_reset();
  endtask

  task automatic test_paddle_saturate();
    do_reset();
    for (int f = 0; f < 60; f++) begin
      frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL paddle_down f%0d: got %h expected %h", f, dut_vec, exp_vec());
      end
      if (f == 0) begin
        checks++;
        if (paddle_l_y !== 10'd224) begin
          errors++;
          $display("FAIL paddle_first_step: got %0d expected 224", paddle_l_y);
        end
      end
    end
    checks++;
    if (paddle_l_y !== 10'd430) begin
      errors++;
      $display("FAIL paddle_saturate: got %0d expected 430", paddle_l_y);
    end
  endtask

  task automatic test_both_pressed();
    do_reset();
    for (int f = 0; f < 5; f++) frame(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({paddle_l_y, paddle_r_y} !== {10'd220, 10'd220}) begin
      errors++;
      $display("FAIL both_pressed: got %0d/%0d expected 220/220", paddle_l_y, paddle_r_y);
    end
  endtask

  task automatic test_serve();
    do_reset();
    for (int f = 0; f < 10; f++) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({ball_x, ball_y} !== {10'd316, 10'd236}) begin
      errors++;
      $display("FAIL serve_hold: got (%0d,%0d) expected (316,236)", ball_x, ball_y);
    end
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({ball_x, ball_y} !== {10'd318, 10'd238}) begin
      errors++;
      $display("FAIL serve_launch: got (%0d,%0d) expected (318,238)", ball_x, ball_y);
    end
  endtask

  task automatic test_pixel();
    int px[4] = '{316, 25, 100, 323};
    int py[4] = '{236, 230, 100, 243};
    logic [1:0] ex[4] = '{2'b10, 2'b01, 2'b00, 2'b10};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, px[k], py[k]);
      checks++;
      if (obj_code !== ex[k]) begin
        errors++;
        $display("FAIL pixel_(%0d,%0d): got %b expected %b", px[k], py[k], obj_code, ex[k]);
      end
    end
  endtask

  task automatic test_point();
    int f;
    do_reset();
    frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (f = 0; f < 2000 && m_mode != 2; f++) begin
      frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL point_play f%0d: got %h expected %h", f, dut_vec, exp_vec());
      end
    end
    checks++;
    if (m_mode != 2 || {ball_x, ball_y} !== {10'd316, 10'd236} || (score_l + score_r) !== 4'd1) begin
      errors++;
      $display("FAIL point_entry: got ball (%0d,%0d) scores %0d:%0d expected centre and one point",
               ball_x, ball_y, score_l, score_r);
    end
    // Serve held throughout: ball must sit at centre until the pause is over.
    for (int k = 0; k < 62; k++) begin
      frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec() || (k < 61 && ball_x !== 10'd316)) begin
        errors++;
        $display("FAIL point_pause k%0d: got %h expected %h", k, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_left_hit();
    int f, hits0, sl0, sr0, target;
    bit ul, dl;
    do_reset();
    hits0 = m_left_hits;
    sl0 = 0; sr0 = 0;
    for (f = 0; f < 3000 && m_left_hits == hits0; f++) begin
      target = m_by - 34;
      ul = (m_pl > target);
      dl = (m_pl < target);
      sl0 = m_sl; sr0 = m_sr;
      frame(ul, dl, 1'b1, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL left_hit_play f%0d: got %h expected %h", f, dut_vec, exp_vec());
      end
    end
    checks++;
    if (m_left_hits == hits0 || ball_x !== 10'd31 || score_l !== 4'(sl0) || score_r !== 4'(sr0)) begin
      errors++;
      $display("FAIL left_hit: got ball_x %0d scores %0d:%0d expected 31 and %0d:%0d",
               ball_x, score_l, score_r, sl0, sr0);
    end
  endtask

  task automatic test_game_over();
    int f;
    logic [39:0] frozen;
    do_reset();
    for (f = 0; f < 8000 && m_mode != 3; f++) begin
      frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL game_play f%0d: got %h expected %h", f, dut_vec, exp_vec());
      end
    end
    checks++;
    if (m_mode != 3 || game_over !== 1'b1 || !(score_l == 4'd7 || score_r == 4'd7)) begin
      errors++;
      $display("FAIL game_over_entry: got game_over %b scores %0d:%0d expected 1 and a 7",
               game_over, score_l, score_r);
    end
    frozen = {paddle_l_y, paddle_r_y, ball_x, ball_y};
    for (int k = 0; k < 5; k++) begin
      frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if ({paddle_l_y, paddle_r_y, ball_x, ball_y} !== frozen || game_over !== 1'b1) begin
        errors++;
        $display("FAIL game_over_frozen k%0d: got %h expected %h", k,
                 {paddle_l_y, paddle_r_y, ball_x, ball_y}, frozen);
      end
    end
    frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({paddle_l_y, paddle_r_y, ball_x, ball_y, score_l, score_r, game_over} !==
        {10'd220, 10'd220, 10'd316, 10'd236, 4'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL game_restart: got %h expected %h",
               {paddle_l_y, paddle_r_y, ball_x, ball_y, score_l, score_r, game_over},
               {10'd220, 10'd220, 10'd316, 10'd236, 4'd0, 4'd0, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int f = 0; f < 20; f++) frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // Arm a tick, then pull reset before the edge that would take it.
    iVS = 1'b1;
    #2;
    iRST_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== {10'd220, 10'd220, 10'd316, 10'd236, 4'd0, 4'd0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", dut_vec,
               {10'd220, 10'd220, 10'd316, 10'd236, 4'd0, 4'd0, 1'b0, 2'b00});
    end
    do_reset();
    frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_resume: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  initial begin
    m_left_hits = 0;
    model_reset();
    test_reset();
    test_paddle_saturate();
    test_both_pressed();
    test_serve();
    test_pixel();
    test_point();
    test_left_hit();
    test_game_over();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
